// File: rtl/sprite_mover_if.sv
// sprite_mover_if: wall-map ROM bus between the sprite mover and its
// synchronous rectangle ROM.
//   rect_addr : ROM address driven by the mover
//   rect_data : {x0,y0,x1,y1} word, valid one cycle after its address
// Modports: master (mover side), slave (ROM side).
interface sprite_mover_if #(
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]        rect_addr;
  logic [2*(X_W+Y_W)-1:0]   rect_data;

  modport master (output rect_addr, input  rect_data);
  modport slave  (input  rect_addr, output rect_data);
endinterface

// File: rtl/sprite_mover.sv
// sprite_mover: on each frame tick, scans the wall-map ROM and tests the
// sprite's shifted box for every direction against each wall and the
// screen bounds, then applies one STEP move in the chosen direction.
//   clk, reset          : clock, synchronous active-high reset
//   tick                : move request, one pulse per frame
//   n8_right/up/left/down : direction request levels
//   rom                 : wall-map ROM bus (rect_addr out, rect_data in)
//   top_left            : sprite {x0,y0}
//   bottom_right        : sprite {x0+SIZE,y0+SIZE}
//   dir                 : 0 still, 1 right, 2 up, 3 left, 4 down
//   busy                : scan in progress
//   move_done           : one-cycle pulse after each decision
module sprite_mover #(
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int SIZE      = 25,
  parameter int STEP      = 1,
  parameter int NUM_RECTS = 21,
  parameter int ADDR_W    = 5,
  parameter int INIT_X    = 240,
  parameter int INIT_Y    = 300,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 n8_right,
  input  logic                 n8_up,
  input  logic                 n8_left,
  input  logic                 n8_down,
  sprite_mover_if.master       rom,
  output logic [X_W+Y_W-1:0]   top_left,
  output logic [X_W+Y_W-1:0]   bottom_right,
  output logic [2:0]           dir,
  output logic                 busy,
  output logic                 move_done
);
  localparam int RW = 2*(X_W+Y_W);

  // One-bit-wider copies so a left/up step from 0 shows up as a large
  // out-of-range value instead of wrapping to a legal coordinate.
  localparam logic [X_W:0] STEP_X = (X_W+1)'(STEP);
  localparam logic [Y_W:0] STEP_Y = (Y_W+1)'(STEP);
  localparam logic [X_W:0] SIZE_X = (X_W+1)'(SIZE);
  localparam logic [Y_W:0] SIZE_Y = (Y_W+1)'(SIZE);
  localparam logic [X_W:0] XMAX_X = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0] YMAX_Y = (Y_W+1)'(Y_MAX);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_LAST, S_DECIDE} state_t;
  typedef enum logic [2:0] {D_NONE = 3'd0, D_RIGHT = 3'd1, D_UP = 3'd2,
                            D_LEFT = 3'd3, D_DOWN  = 3'd4} dir_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [4:1]        ok_q, ok_d;
  dir_t              dir_q, dir_d, pend_q, pend_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              done_d;
  logic [ADDR_W-1:0] addr;

  // Wall rectangle from the ROM word, widened for comparison.
  logic [X_W:0] rx0, rx1;
  logic [Y_W:0] ry0, ry1;
  assign rx0 = {1'b0, rom.rect_data[RW-1 -: X_W]};
  assign ry0 = {1'b0, rom.rect_data[RW-X_W-1 -: Y_W]};
  assign rx1 = {1'b0, rom.rect_data[X_W+Y_W-1 -: X_W]};
  assign ry1 = {1'b0, rom.rect_data[Y_W-1:0]};

  // Candidate boxes per direction (index = dir code 1..4).
  logic [X_W:0] cx0 [1:4];
  logic [X_W:0] cx1 [1:4];
  logic [Y_W:0] cy0 [1:4];
  logic [Y_W:0] cy1 [1:4];
  logic [4:1]   hit, inb;
  logic [7:0]   avail;

  always_comb begin
    for (int d = 1; d <= 4; d++) begin
      cx0[d] = {1'b0, x_q};
      cx1[d] = {1'b0, x_q} + SIZE_X;
      cy0[d] = {1'b0, y_q};
      cy1[d] = {1'b0, y_q} + SIZE_Y;
    end
    cx0[1] = {1'b0, x_q} + STEP_X;  cx1[1] = {1'b0, x_q} + SIZE_X + STEP_X;
    cy0[2] = {1'b0, y_q} - STEP_Y;  cy1[2] = {1'b0, y_q} + SIZE_Y - STEP_Y;
    cx0[3] = {1'b0, x_q} - STEP_X;  cx1[3] = {1'b0, x_q} + SIZE_X - STEP_X;
    cy0[4] = {1'b0, y_q} + STEP_Y;  cy1[4] = {1'b0, y_q} + SIZE_Y + STEP_Y;
    for (int d = 1; d <= 4; d++) begin
      hit[d] = (cx0[d] <= rx1) && (cx1[d] >= rx0) &&
               (cy0[d] <= ry1) && (cy1[d] >= ry0);
      inb[d] = (cx0[d] <= XMAX_X) && (cx1[d] <= XMAX_X) &&
               (cy0[d] <= YMAX_Y) && (cy1[d] <= YMAX_Y);
    end
  end

  // Bit 0 is STILL, which is always allowed.
  assign avail = {3'b000, ok_q & inb, 1'b1};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ok_d    = ok_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;
    addr    = '0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          idx_d   = '0;
          ok_d    = '1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        addr  = idx_q;
        idx_d = idx_q + 1'b1;
        // Read data lags the address by one cycle; nothing to test at i=0.
        if (idx_q != '0) ok_d = ok_q & ~hit;
        if (idx_q == ADDR_W'(NUM_RECTS-1)) state_d = S_LAST;
      end
      S_LAST: begin
        ok_d    = ok_q & ~hit;
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (pend_q != D_NONE && avail[pend_q]) begin
          dir_d  = pend_q;
          pend_d = D_NONE;
        end else if (!avail[dir_q]) begin
          dir_d  = D_NONE;
        end
        case (dir_d)
          D_RIGHT: x_d = x_q + X_W'(STEP);
          D_UP:    y_d = y_q - Y_W'(STEP);
          D_LEFT:  x_d = x_q - X_W'(STEP);
          D_DOWN:  y_d = y_q + Y_W'(STEP);
          default: ;
        endcase
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A live request always reloads pending, even over a clear in S_DECIDE,
    // so a held key keeps steering.
    if (n8_right)     pend_d = D_RIGHT;
    else if (n8_up)   pend_d = D_UP;
    else if (n8_left) pend_d = D_LEFT;
    else if (n8_down) pend_d = D_DOWN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      ok_q      <= '1;
      dir_q     <= D_NONE;
      pend_q    <= D_NONE;
      x_q       <= X_W'(INIT_X);
      y_q       <= Y_W'(INIT_Y);
      move_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ok_q      <= ok_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      x_q       <= x_d;
      y_q       <= y_d;
      move_done <= done_d;
    end
  end

  assign rom.rect_addr  = addr;
  assign top_left       = {x_q, y_q};
  assign bottom_right   = {x_q + X_W'(SIZE), y_q + Y_W'(SIZE)};
  assign dir            = dir_q;
  assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_sprite_mover.sv
module tb_sprite_mover;
  localparam int SIZE = 25, STEP = 1, NR = 21, XMAX = 639, YMAX = 479;

  logic clk = 0, reset = 1;
  logic tick_a = 0, r_a = 0, u_a = 0, l_a = 0, d_a = 0;
  logic tick_b = 0, l_b = 0, zero_b = 0;
  logic [18:0] tl_a, br_a, tl_b, br_b;
  logic [2:0]  dir_a, dir_b;
  logic busy_a, busy_b, md_a, md_b;

  sprite_mover_if #(.X_W(10), .Y_W(9), .ADDR_W(5)) ifa ();
  sprite_mover_if #(.X_W(10), .Y_W(9), .ADDR_W(5)) ifb ();

  sprite_mover dut_a (.clk(clk), .reset(reset), .tick(tick_a),
    .n8_right(r_a), .n8_up(u_a), .n8_left(l_a), .n8_down(d_a), .rom(ifa),
    .top_left(tl_a), .bottom_right(br_a), .dir(dir_a), .busy(busy_a), .move_done(md_a));

  sprite_mover #(.INIT_X(0)) dut_b (.clk(clk), .reset(reset), .tick(tick_b),
    .n8_right(zero_b), .n8_up(zero_b), .n8_left(l_b), .n8_down(zero_b), .rom(ifb),
    .top_left(tl_b), .bottom_right(br_b), .dir(dir_b), .busy(busy_b), .move_done(md_b));

  always #5 clk = ~clk;

  logic [37:0] rom_a [0:31];
  logic [37:0] rom_b [0:31];
  always @(posedge clk) begin
    ifa.rect_data <= rom_a[ifa.rect_addr];
    ifb.rect_data <= rom_b[ifb.rect_addr];
  end

  // Reference model: integer geometry, walls kept as plain arrays.
  int wx0 [NR], wy0 [NR], wx1 [NR], wy1 [NR];
  int mx, my, mdir, mpend;
  int tests_run = 0, tests_fail = 0;

  function automatic logic [37:0] pack(int x0, int y0, int x1, int y1);
    return {10'(x0), 9'(y0), 10'(x1), 9'(y1)};
  endfunction

  task automatic set_wall(int i, int x0, int y0, int x1, int y1);
    wx0[i] = x0; wy0[i] = y0; wx1[i] = x1; wy1[i] = y1;
    rom_a[i] = pack(x0, y0, x1, y1);
  endtask

  task automatic load_far();
    for (int i = 0; i < NR; i++) set_wall(i, 1000, 500, 1010, 510);
  endtask

  function automatic bit blocked(int d);
    int cx0, cy0, cx1, cy1;
    cx0 = mx; cy0 = my;
    case (d)
      1: cx0 = mx + STEP;
      2: cy0 = my - STEP;
      3: cx0 = mx - STEP;
      4: cy0 = my + STEP;
      default: ;
    endcase
    cx1 = cx0 + SIZE; cy1 = cy0 + SIZE;
    if (cx0 < 0 || cy0 < 0 || cx1 > XMAX || cy1 > YMAX) return 1;
    for (int i = 0; i < NR; i++)
      if (cx0 <= wx1[i] && cx1 >= wx0[i] && cy0 <= wy1[i] && cy1 >= wy0[i]) return 1;
    return 0;
  endfunction

  function automatic int prio(bit r, bit u, bit l, bit d);
    if (r) return 1;
    if (u) return 2;
    if (l) return 3;
    if (d) return 4;
    return 0;
  endfunction

  task automatic mdl_move();
    if (mpend != 0 && !blocked(mpend)) begin mdir = mpend; mpend = 0; end
    else if (mdir != 0 && blocked(mdir)) mdir = 0;
    case (mdir)
      1: mx += STEP;
      2: my -= STEP;
      3: mx -= STEP;
      4: my += STEP;
      default: ;
    endcase
    if (r_a | u_a | l_a | d_a) mpend = prio(r_a, u_a, l_a, d_a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    r_a = 0; u_a = 0; l_a = 0; d_a = 0; l_b = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    mx = 240; my = 300; mdir = 0; mpend = 0;
  endtask

  task automatic pulse_n8(bit r, bit u, bit l, bit d);
    @(negedge clk);
    r_a = r; u_a = u; l_a = l; d_a = d;
    @(negedge clk);
    r_a = 0; u_a = 0; l_a = 0; d_a = 0;
    if (r | u | l | d) mpend = prio(r, u, l, d);
  endtask

  task automatic hold_n8(bit r, bit u, bit l, bit d);
    @(negedge clk);
    r_a = r; u_a = u; l_a = l; d_a = d;
    if (r | u | l | d) mpend = prio(r, u, l, d);
  endtask

  // Tick DUT a (sel=0) or b (sel=1); edges = edges after the sampling
  // edge until move_done is seen, -1 if it never comes.
  task automatic do_move(input bit sel, output int edges);
    @(negedge clk);
    if (sel) tick_b = 1; else tick_a = 1;
    @(posedge clk); #1;
    tick_a = 0; tick_b = 0;
    edges = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if ((sel ? md_b : md_a) === 1'b1) begin edges = n; break; end
    end
  endtask

  task automatic chk_model(string nm, int edges);
    logic [18:0] etl, ebr;
    etl = {10'(mx), 9'(my)};
    ebr = {10'(mx + SIZE), 9'(my + SIZE)};
    tests_run++;
    if (edges != 23) begin tests_fail++; $display("FAIL %s latency: got %0d exp 23", nm, edges); end
    tests_run++;
    if (tl_a !== etl) begin tests_fail++; $display("FAIL %s top_left: got %0h exp %0h", nm, tl_a, etl); end
    tests_run++;
    if (br_a !== ebr) begin tests_fail++; $display("FAIL %s bottom_right: got %0h exp %0h", nm, br_a, ebr); end
    tests_run++;
    if (dir_a !== 3'(mdir)) begin tests_fail++; $display("FAIL %s dir: got %0d exp %0d", nm, dir_a, mdir); end
  endtask

  task automatic test_reset();
    tests_run++;
    if (tl_a !== {10'd240, 9'd300}) begin tests_fail++; $display("FAIL reset top_left: got %0h", tl_a); end
    tests_run++;
    if (br_a !== {10'd265, 9'd325}) begin tests_fail++; $display("FAIL reset bottom_right: got %0h", br_a); end
    tests_run++;
    if (dir_a !== 3'd0 || busy_a !== 1'b0 || md_a !== 1'b0) begin
      tests_fail++; $display("FAIL reset dir/busy/done: got %0d/%0b/%0b exp 0/0/0", dir_a, busy_a, md_a); end
    tests_run++;
    if (ifa.rect_addr !== 5'd0) begin tests_fail++; $display("FAIL reset rect_addr: got %0d exp 0", ifa.rect_addr); end
  endtask

  task automatic test_free_run();
    int e;
    do_reset(); load_far();
    hold_n8(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin do_move(0, e); mdl_move(); chk_model("free_run", e); end
    tests_run++;
    if (tl_a[18:9] !== 10'd243 || br_a[18:9] !== 10'd268 || dir_a !== 3'd1) begin
      tests_fail++; $display("FAIL free_run final: got x0=%0d x1=%0d dir=%0d exp 243/268/1", tl_a[18:9], br_a[18:9], dir_a); end
  endtask

  task automatic test_wall_block();
    int e;
    do_reset(); load_far(); set_wall(7, 267, 290, 280, 340);
    hold_n8(1, 0, 0, 0);
    do_move(0, e); mdl_move(); chk_model("wall_tick1", e);
    tests_run++;
    if (br_a[18:9] !== 10'd266) begin tests_fail++; $display("FAIL wall_tick1 x1: got %0d exp 266", br_a[18:9]); end
    do_move(0, e); mdl_move(); chk_model("wall_tick2", e);
    tests_run++;
    if (br_a[18:9] !== 10'd266 || dir_a !== 3'd0) begin
      tests_fail++; $display("FAIL wall_tick2: got x1=%0d dir=%0d exp 266/0", br_a[18:9], dir_a); end
  endtask

  task automatic test_pending_turn();
    int e;
    do_reset(); load_far(); set_wall(20, 240, 280, 270, 299);
    pulse_n8(1, 0, 0, 0);
    do_move(0, e); mdl_move(); chk_model("turn_t1", e);
    pulse_n8(0, 1, 0, 0);
    for (int k = 2; k <= 31; k++) begin do_move(0, e); mdl_move(); chk_model("turn_run", e); end
    tests_run++;
    if (tl_a !== {10'd271, 9'd300} || dir_a !== 3'd1) begin
      tests_fail++; $display("FAIL turn_t31: got tl=%0h dir=%0d exp x0=271 y0=300 dir=1", tl_a, dir_a); end
    do_move(0, e); mdl_move(); chk_model("turn_t32", e);
    tests_run++;
    if (tl_a !== {10'd271, 9'd299} || dir_a !== 3'd2) begin
      tests_fail++; $display("FAIL turn_t32: got tl=%0h dir=%0d exp x0=271 y0=299 dir=2", tl_a, dir_a); end
    // pending cleared by the turn: keep moving up
    do_move(0, e); mdl_move(); chk_model("turn_t33", e);
  endtask

  task automatic test_left_edge();
    int e;
    do_reset();
    @(negedge clk); l_b = 1;
    do_move(1, e);
    tests_run++;
    if (e != 23) begin tests_fail++; $display("FAIL left_edge latency: got %0d exp 23", e); end
    tests_run++;
    if (tl_b !== {10'd0, 9'd300} || br_b[18:9] !== 10'd25 || dir_b !== 3'd0) begin
      tests_fail++; $display("FAIL left_edge: got tl=%0h x1=%0d dir=%0d exp x0=0 x1=25 dir=0", tl_b, br_b[18:9], dir_b); end
    l_b = 0;
  endtask

  task automatic test_back_to_back();
    int n, extra;
    do_reset(); load_far();
    pulse_n8(0, 0, 0, 1);
    @(negedge clk); tick_a = 1;
    @(posedge clk); #1; tick_a = 0;
    for (int k = 0; k < NR; k++) begin
      tests_run++;
      if (ifa.rect_addr !== 5'(k) || busy_a !== 1'b1) begin
        tests_fail++; $display("FAIL scan addr/busy: got %0d/%0b exp %0d/1", ifa.rect_addr, busy_a, k); end
      tick_a = (k == 5);   // dropped: arrives mid-scan
      @(posedge clk); #1;
    end
    tick_a = 0;
    n = -1;
    for (int j = 1; j <= 10; j++) begin @(posedge clk); #1; if (md_a) begin n = j; break; end end
    mdl_move();
    chk_model("b2b", (n == 2) ? 23 : n);
    extra = 0;
    for (int j = 0; j < 40; j++) begin @(posedge clk); #1; if (md_a) extra++; end
    tests_run++;
    if (extra != 0 || busy_a !== 1'b0) begin
      tests_fail++; $display("FAIL dropped_tick: got extra=%0d busy=%0b exp 0/0", extra, busy_a); end
  endtask

  task automatic test_reset_mid_scan();
    int e, cnt;
    do_reset(); load_far();
    pulse_n8(1, 0, 0, 0);
    do_move(0, e); mdl_move(); chk_model("pre_reset", e);
    @(negedge clk); tick_a = 1;
    @(posedge clk); #1; tick_a = 0;
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    tests_run++;
    if (busy_a !== 1'b0 || tl_a !== {10'd240, 9'd300} || dir_a !== 3'd0) begin
      tests_fail++; $display("FAIL reset_mid: got busy=%0b tl=%0h dir=%0d exp 0/{240,300}/0", busy_a, tl_a, dir_a); end
    @(negedge clk); reset = 0;
    mx = 240; my = 300; mdir = 0; mpend = 0;
    cnt = 0;
    for (int j = 0; j < 30; j++) begin @(posedge clk); #1; if (md_a) cnt++; end
    tests_run++;
    if (cnt != 0) begin tests_fail++; $display("FAIL reset_mid move_done: got %0d pulses exp 0", cnt); end
  endtask

  task automatic test_random();
    int e, x0, y0;
    bit [3:0] m;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      x0 = $urandom_range(0, 639); y0 = $urandom_range(0, 460);
      set_wall(i, x0, y0, x0 + $urandom_range(0, 40), y0 + $urandom_range(0, 40));
    end
    for (int k = 0; k < 40; k++) begin
      m = 4'($urandom_range(0, 15));
      if (m != 0) pulse_n8(m[3], m[2], m[1], m[0]);
      do_move(0, e); mdl_move(); chk_model("random", e);
    end
  endtask

  initial begin
    load_far();
    for (int i = 0; i < 32; i++) rom_b[i] = pack(1000, 500, 1010, 510);
    for (int i = NR; i < 32; i++) rom_a[i] = pack(1000, 500, 1010, 510);
    mx = 240; my = 300; mdir = 0; mpend = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    test_reset();
    test_free_run();
    test_wall_block();
    test_pending_turn();
    test_left_edge();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end
endmodule
